spi_host: RTL and testbench

Byte-oriented SPI master (mode 0, MSB first) that drives the four-wire SPI port of `top`, which is an SPI peripheral. Benches and bring-up harnesses use it to shift command and data bytes into the chip and read back responses. A local request/response handshake hands one byte per transfer to the block. Chip select can be held low across bytes to form multi-byte frames.

---
 rtl/spi_host.sv | 179 +++++++++++++++++
 tb/tb_spi_host.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_host.sv
// spi_host: byte-oriented SPI master, mode 0, MSB first.
// One transfer per accepted start; ss can be held low across bytes to build frames.
module spi_host #(
    parameter int unsigned CLK_DIV    = 4,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  hold_ss,
    input  logic                  release_ss,
    output logic                  busy,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  sck,
    output logic                  ss,
    output logic                  mosi,
    input  logic                  miso
);

    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned BIT_W = $clog2(DATA_WIDTH + 1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        HIGH,
        LOW,
        HOLD,
        GAP
    } state_t;

    state_t                state, state_n;
    logic [DIV_W-1:0]      div_cnt, div_cnt_n;
    logic [BIT_W-1:0]      bit_cnt, bit_cnt_n;
    logic [DATA_WIDTH-1:0] tx_shift, tx_shift_n;
    logic [DATA_WIDTH-1:0] rx_shift, rx_shift_n;
    logic [DATA_WIDTH-1:0] rx_data_n;
    logic                  hold_q, hold_n;
    logic                  sck_n, ss_n, mosi_n, busy_n, rx_valid_n;

    logic                  div_last;
    logic [BIT_W-1:0]      bit_inc;
    logic [DATA_WIDTH-1:0] tx_next;
    logic [DATA_WIDTH-1:0] rx_sampled;

    // State register and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            div_cnt  <= '0;
            bit_cnt  <= '0;
            tx_shift <= '0;
            rx_shift <= '0;
            rx_data  <= '0;
            hold_q   <= 1'b0;
            sck      <= 1'b0;
            ss       <= 1'b1;
            mosi     <= 1'b0;
            busy     <= 1'b0;
            rx_valid <= 1'b0;
        end else begin
            state    <= state_n;
            div_cnt  <= div_cnt_n;
            bit_cnt  <= bit_cnt_n;
            tx_shift <= tx_shift_n;
            rx_shift <= rx_shift_n;
            rx_data  <= rx_data_n;
            hold_q   <= hold_n;
            sck      <= sck_n;
            ss       <= ss_n;
            mosi     <= mosi_n;
            busy     <= busy_n;
            rx_valid <= rx_valid_n;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_n    = state;
        div_cnt_n  = div_cnt;
        bit_cnt_n  = bit_cnt;
        tx_shift_n = tx_shift;
        rx_shift_n = rx_shift;
        rx_data_n  = rx_data;
        hold_n     = hold_q;
        sck_n      = sck;
        ss_n       = ss;
        mosi_n     = mosi;
        busy_n     = busy;
        rx_valid_n = 1'b0;

        div_last   = (div_cnt == DIV_W'(CLK_DIV - 1));
        bit_inc    = bit_cnt + BIT_W'(1);
        tx_next    = tx_shift << 1;
        rx_sampled = (rx_shift << 1) | DATA_WIDTH'(miso);

        case (state)
            IDLE, HOLD: begin
                if (start) begin
                    // Accepting from HOLD keeps ss low, so the frame continues seamlessly
                    state_n    = SETUP;
                    div_cnt_n  = '0;
                    bit_cnt_n  = '0;
                    tx_shift_n = tx_data;
                    hold_n     = hold_ss;
                    sck_n      = 1'b0;
                    ss_n       = 1'b0;
                    mosi_n     = tx_data[DATA_WIDTH-1];
                    busy_n     = 1'b1;
                end else if ((state == HOLD) && release_ss) begin
                    state_n   = GAP;
                    div_cnt_n = '0;
                    ss_n      = 1'b1;
                    mosi_n    = 1'b0;
                    busy_n    = 1'b1;
                end
            end
            SETUP: begin
                div_cnt_n = div_cnt + DIV_W'(1);
                if (div_last) begin
                    state_n    = HIGH;
                    div_cnt_n  = '0;
                    sck_n      = 1'b1;
                    rx_shift_n = rx_sampled;
                end
            end
            HIGH: begin
                div_cnt_n = div_cnt + DIV_W'(1);
                if (div_last) begin
                    state_n   = LOW;
                    div_cnt_n = '0;
                    sck_n     = 1'b0;
                    bit_cnt_n = bit_inc;
                    if (bit_inc < BIT_W'(DATA_WIDTH)) begin
                        tx_shift_n = tx_next;
                        mosi_n     = tx_next[DATA_WIDTH-1];
                    end
                end
            end
            LOW: begin
                div_cnt_n = div_cnt + DIV_W'(1);
                if (div_last) begin
                    div_cnt_n = '0;
                    if (bit_cnt < BIT_W'(DATA_WIDTH)) begin
                        state_n    = HIGH;
                        sck_n      = 1'b1;
                        rx_shift_n = rx_sampled;
                    end else begin
                        rx_data_n  = rx_shift;
                        rx_valid_n = 1'b1;
                        if (hold_q) begin
                            state_n = HOLD;
                            busy_n  = 1'b0;
                        end else begin
                            state_n = GAP;
                            ss_n    = 1'b1;
                            mosi_n  = 1'b0;
                        end
                    end
                end
            end
            GAP: begin
                // Guarantees a minimum ss-high time between frames
                div_cnt_n = div_cnt + DIV_W'(1);
                if (div_last) begin
                    state_n   = IDLE;
                    div_cnt_n = '0;
                    busy_n    = 1'b0;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_spi_host.sv
// tb_spi_host: directed bench for spi_host with a timing-rule model and a mode-0 peripheral.
module tb_spi_host;

    localparam int D = 2;
    localparam int W = 8;
    localparam int T = D * (2 * W + 1);

    logic       clk, reset, start, hold_ss, release_ss, miso;
    logic [7:0] tx_data, rx_data;
    logic       busy, rx_valid, sck, ss, mosi;

    logic       start1;
    logic [7:0] tx1, rx_data1;
    logic       busy1, rx_valid1, sck1, ss1, mosi1;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    spi_host #(.CLK_DIV(D), .DATA_WIDTH(W)) u_dut (
        .clk(clk), .reset(reset), .start(start), .tx_data(tx_data),
        .hold_ss(hold_ss), .release_ss(release_ss), .busy(busy),
        .rx_data(rx_data), .rx_valid(rx_valid), .sck(sck), .ss(ss),
        .mosi(mosi), .miso(miso)
    );

    spi_host #(.CLK_DIV(1), .DATA_WIDTH(8)) u_dut1 (
        .clk(clk), .reset(reset), .start(start1), .tx_data(tx1),
        .hold_ss(1'b0), .release_ss(1'b0), .busy(busy1),
        .rx_data(rx_data1), .rx_valid(rx_valid1), .sck(sck1), .ss(ss1),
        .mosi(mosi1), .miso(1'b0)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Peripheral: presents resp MSB first, advancing on each falling sck edge
    logic [7:0] resp = 8'h00;
    int         pidx = 0;
    always @(negedge sck or posedge ss) begin
        if (ss) pidx = 0;
        else    pidx = pidx + 1;
    end
    assign miso = ss ? 1'b0 : resp[7 - (pidx % 8)];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    endtask

    // Model: outputs derived from cycle offset within a transfer
    typedef enum int {M_IDLE, M_XFER, M_HOLD, M_GAP} mmode_t;
    mmode_t     m     = M_IDLE;
    int         mc    = 0;
    int         mg    = 0;
    logic [7:0] mtx   = 8'h00;
    logic [7:0] mresp = 8'h00;
    logic [7:0] e_rxd = 8'h00;
    logic       mhold = 1'b0;
    logic       mrv   = 1'b0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m = M_IDLE; mc = 0; mg = 0; e_rxd = 8'h00; mrv = 1'b0;
        end else begin
            mrv = 1'b0;
            case (m)
                M_IDLE, M_HOLD: begin
                    if (start) begin
                        mtx = tx_data; mhold = hold_ss; mresp = resp; mc = 0; m = M_XFER;
                    end else if (m == M_HOLD && release_ss) begin
                        m = M_GAP; mg = 0;
                    end
                end
                M_XFER: begin
                    mc++;
                    if (mc == T) begin
                        mrv = 1'b1; e_rxd = mresp; mg = 0;
                        m = mhold ? M_HOLD : M_GAP;
                    end
                end
                M_GAP: begin
                    mg++;
                    if (mg == D) m = M_IDLE;
                end
                default: ;
            endcase
        end
    end

    function automatic logic [4:0] model_outs();
        logic s_sck, s_ss, s_mosi, s_busy;
        int   k;
        s_sck = 1'b0; s_ss = 1'b1; s_mosi = 1'b0; s_busy = 1'b0;
        case (m)
            M_XFER: begin
                s_ss   = 1'b0;
                s_busy = 1'b1;
                s_sck  = (mc >= D) && ((mc / D) % 2 == 1);
                k      = mc / (2 * D);
                if (k > W - 1) k = W - 1;
                s_mosi = mtx[W - 1 - k];
            end
            M_HOLD: begin
                s_ss   = 1'b0;
                s_mosi = mtx[0];
            end
            M_GAP:   s_busy = 1'b1;
            default: ;
        endcase
        return {s_sck, s_ss, s_mosi, s_busy, mrv};
    endfunction

    // Cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        if (reset) begin
            check("outs{sck,ss,mosi,busy,rx_valid}", 32'({sck, ss, mosi, busy, rx_valid}), 32'(model_outs()));
            check("rx_data", 32'(rx_data), 32'(e_rxd));
        end
    end

    // Event monitor
    int         n_rise = 0, n_ss_rise = 0, n_ss_fall = 0;
    int         ss_rise_cyc = 0, busy_fall_cyc = 0;
    logic       rise_mosi[$];
    int         rxv_cyc[$];
    logic [7:0] rxv_dat[$];
    logic       sck_q = 1'b0, ss_q = 1'b1, busy_q = 1'b0, sck1_q = 1'b0;
    int         n_rise1 = 0, n_tog1 = 0, n_rxv1 = 0, rxv1_cyc = 0;
    logic [7:0] rxv1_dat = 8'h00;

    always @(negedge clk) begin
        if (reset) begin
            if (sck && !sck_q) begin n_rise++; rise_mosi.push_back(mosi); end
            if (ss && !ss_q) begin n_ss_rise++; ss_rise_cyc = cyc; end
            if (!ss && ss_q) n_ss_fall++;
            if (!busy && busy_q) busy_fall_cyc = cyc;
            if (rx_valid) begin rxv_cyc.push_back(cyc); rxv_dat.push_back(rx_data); end
            if (sck1 != sck1_q) n_tog1++;
            if (sck1 && !sck1_q) n_rise1++;
            if (rx_valid1) begin n_rxv1++; rxv1_cyc = cyc; rxv1_dat = rx_data1; end
        end
        sck_q = sck; ss_q = ss; busy_q = busy; sck1_q = sck1;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic clear_mon();
        n_rise = 0; n_ss_rise = 0; n_ss_fall = 0;
        rise_mosi.delete(); rxv_cyc.delete(); rxv_dat.delete();
    endtask

    task automatic send(input logic [7:0] b, input logic h, output int base);
        tx_data = b; hold_ss = h; start = 1'b1;
        tick(1);
        start = 1'b0; tx_data = 8'($urandom); hold_ss = 1'($urandom);
        base = cyc;
    endtask

    task automatic wait_rxv(input int n, input int budget);
        int k = 0;
        while (rxv_cyc.size() < n && k < budget) begin tick(1); k++; end
        check("wait_rx_valid", 32'(rxv_cyc.size()), 32'(n));
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        int         base, b2, k;
        logic [7:0] mb;
        clk = 1'b0; reset = 1'b0; start = 1'b0; tx_data = 8'h00; hold_ss = 1'b0;
        release_ss = 1'b0; start1 = 1'b0; tx1 = 8'h00;
        tick(3);
        check("reset_outs", 32'({sck, ss, mosi, busy, rx_valid}), 32'(5'b01000));
        check("reset_rx_data", 32'(rx_data), 32'h0);
        check("reset_outs_div1", 32'({sck1, ss1, mosi1, busy1, rx_valid1, rx_data1}), 32'(13'b0100000000000));
        reset = 1'b1;
        tick(2);

        // Single byte 0xA5, peripheral returns 0x3C
        clear_mon(); resp = 8'h3C;
        send(8'hA5, 1'b0, base);
        wait_rxv(1, 60);
        check("t1_model_rx_data", 32'(e_rxd), 32'h3C);
        check("t1_model_outs", 32'(model_outs()), 32'(5'b01011));
        tick(4);
        mb = 8'h00;
        foreach (rise_mosi[i]) mb = {mb[6:0], rise_mosi[i]};
        check("t1_rises", 32'(n_rise), 32'd8);
        check("t1_mosi_at_rises", 32'(mb), 32'hA5);
        if (rxv_cyc.size() > 0) begin
            check("t1_rx_valid_cycle", 32'(rxv_cyc[0] - base), 32'd34);
            check("t1_rx_data", 32'(rxv_dat[0]), 32'h3C);
        end
        check("t1_ss_high_cycle", 32'(ss_rise_cyc - base), 32'd34);
        check("t1_busy_low_cycle", 32'(busy_fall_cyc - base), 32'd36);

        // Two-byte held frame, second start in the first rx_valid cycle
        clear_mon(); resp = 8'h5A;
        send(8'h12, 1'b1, base);
        wait_rxv(1, 60);
        resp = 8'hC3;
        send(8'h34, 1'b0, b2);
        wait_rxv(2, 60);
        tick(4);
        check("t2_rises", 32'(n_rise), 32'd16);
        check("t2_ss_falls", 32'(n_ss_fall), 32'd1);
        check("t2_ss_rises", 32'(n_ss_rise), 32'd1);
        if (rxv_cyc.size() > 1) begin
            check("t2_rx_spacing", 32'(rxv_cyc[1] - rxv_cyc[0]), 32'(T + 1));
            check("t2_rx0", 32'(rxv_dat[0]), 32'h5A);
            check("t2_rx1", 32'(rxv_dat[1]), 32'hC3);
        end

        // start held every cycle while the transfer runs
        clear_mon(); resp = 8'h81;
        send(8'h96, 1'b0, base);
        while (cyc - base < T + D) begin
            start = 1'b1; tx_data = 8'($urandom); hold_ss = 1'($urandom);
            tick(1);
        end
        start = 1'b0; hold_ss = 1'b0;
        tick(3);
        check("t3_rises", 32'(n_rise), 32'd8);
        check("t3_transfers", 32'(rxv_cyc.size()), 32'd1);
        if (rxv_dat.size() > 0) check("t3_rx", 32'(rxv_dat[0]), 32'h81);

        // HOLD: start and release together, then release alone
        clear_mon(); resp = 8'h24;
        send(8'h3E, 1'b1, base);
        wait_rxv(1, 60);
        tick(3);
        resp = 8'h99;
        tx_data = 8'h71; hold_ss = 1'b1; start = 1'b1; release_ss = 1'b1;
        tick(1);
        start = 1'b0; release_ss = 1'b0; hold_ss = 1'b0;
        wait_rxv(2, 60);
        check("t4_rises", 32'(n_rise), 32'd16);
        check("t4_ss_rises", 32'(n_ss_rise), 32'd0);
        if (rxv_dat.size() > 1) check("t4_rx1", 32'(rxv_dat[1]), 32'h99);
        tick(2);
        release_ss = 1'b1;
        tick(1);
        release_ss = 1'b0;
        check("t4_gap_ss_busy", 32'({ss, busy}), 32'(2'b11));
        tick(D - 1);
        check("t4_gap_last_busy", 32'(busy), 32'd1);
        tick(1);
        check("t4_idle_busy", 32'(busy), 32'd0);

        // Asynchronous reset after the third rising sck edge
        clear_mon(); resp = 8'h6B;
        send(8'hC7, 1'b0, base);
        k = 0;
        while (n_rise < 3 && k < 40) begin tick(1); k++; end
        check("t5_third_rise", 32'(n_rise), 32'd3);
        #2;
        reset = 1'b0;
        #1;
        check("t5_async_outs", 32'({sck, ss, busy, rx_valid}), 32'(4'b0100));
        check("t5_async_mosi_rx", 32'({mosi, rx_data}), 32'h0);
        tick(2);
        reset = 1'b1;
        tick(2);
        clear_mon(); resp = 8'hE1;
        send(8'h5C, 1'b0, base);
        wait_rxv(1, 60);
        if (rxv_cyc.size() > 0) begin
            check("t5_post_rx_cycle", 32'(rxv_cyc[0] - base), 32'd34);
            check("t5_post_rx", 32'(rxv_dat[0]), 32'hE1);
        end
        tick(4);
        check("t5_post_rises", 32'(n_rise), 32'd8);

        // CLK_DIV=1, 0xFF out, miso tied low
        n_tog1 = 0; n_rise1 = 0; n_rxv1 = 0;
        tx1 = 8'hFF; start1 = 1'b1;
        tick(1);
        start1 = 1'b0; tx1 = 8'h00;
        base = cyc;
        k = 0;
        while (n_rxv1 == 0 && k < 40) begin tick(1); k++; end
        tick(3);
        check("t6_rx_valid_seen", 32'(n_rxv1), 32'd1);
        check("t6_rises", 32'(n_rise1), 32'd8);
        check("t6_toggles", 32'(n_tog1), 32'd16);
        check("t6_rx_cycle", 32'(rxv1_cyc - base), 32'd17);
        check("t6_rx_data", 32'(rxv1_dat), 32'h00);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
